// File: rtl/jk_bank_driver_pkg.sv
// Shared types and constants for the JK flip-flop bank driver.
package jk_bank_driver_pkg;

  localparam int unsigned MISMATCH_CNT_W = 16;
  // Retry counter covers MAX_RETRY up to 15.
  localparam int unsigned RETRY_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/jk_excite.sv
// Per-word JK excitation from current Q to requested next Q.
// Build option: JK_BANK_DRIVER_TOGGLE_EN selects toggle drive (j=k=1) for
// changing bits; otherwise changing bits get an explicit set or reset.
module jk_excite #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  logic [WIDTH-1:0] diff;

  // Only bits that must change get a non-zero excitation.
  assign diff = cur ^ nxt;

`ifdef JK_BANK_DRIVER_TOGGLE_EN
  assign j = diff;
  assign k = diff;
`else
  assign j = diff & nxt;
  assign k = diff & cur;
`endif

endmodule

// File: rtl/jk_bank_driver.sv
// Writer side of a JK flip-flop bank: accepts a target word, drives J/K for
// one cycle, checks the bank's Q, retries on mismatch.
// Build option: JK_BANK_DRIVER_TOGGLE_EN (see jk_excite).
module jk_bank_driver
  import jk_bank_driver_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tgt_valid,
  output logic                      tgt_ready,
  input  logic [WIDTH-1:0]          tgt_data,
  input  logic [WIDTH-1:0]          q_fb,
  output logic [WIDTH-1:0]          j,
  output logic [WIDTH-1:0]          k,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [MISMATCH_CNT_W-1:0] mismatch_cnt
);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          target_q, target_d;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic [WIDTH-1:0]          j_d, k_d;
  logic                      busy_d, done_d, err_d, ready_d;
  logic [MISMATCH_CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]          exc_nxt, exc_j, exc_k;

  // Excitation target: incoming word at accept, latched target on retry.
  assign exc_nxt = (state_q == IDLE) ? tgt_data : target_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .cur (q_fb),
    .nxt (exc_nxt),
    .j   (exc_j),
    .k   (exc_k)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      retry_q      <= '0;
      j            <= '0;
      k            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tgt_ready    <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      retry_q      <= retry_d;
      j            <= j_d;
      k            <= k_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      tgt_ready    <= ready_d;
      mismatch_cnt <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = mismatch_cnt;

    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          target_d = tgt_data;
          retry_d  = '0;
          j_d      = exc_j;
          k_d      = exc_k;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          if (mismatch_cnt != '1) begin
            cnt_d = mismatch_cnt + MISMATCH_CNT_W'(1);
          end
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            j_d     = exc_j;
            k_d     = exc_k;
            state_d = DRIVE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver with a behavioural JK bank model.
module tb_jk_bank_driver;

  localparam int unsigned W  = 8;
  localparam int unsigned MR = 2;

  logic         clk;
  logic         rst;
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt_data;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         busy;
  logic         done;
  logic         err;
  logic [15:0]  mismatch_cnt;

  // Bank environment: JK flops with optional stuck bits and a preload port.
  logic [W-1:0] bank_q;
  logic [W-1:0] s0, s1;
  logic         load_en;
  logic [W-1:0] load_val;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_mm   = 0;

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk          (clk),
    .rst          (rst),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .tgt_data     (tgt_data),
    .q_fb         (q_fb),
    .j            (j),
    .k            (k),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign q_fb = bank_q;

  // JK bank: characteristic equation per bit, then stuck-at overrides.
  always @(posedge clk) begin
    if (load_en) bank_q <= load_val;
    else         bank_q <= (((j & ~bank_q) | (~k & bank_q)) & ~s0) | s1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference excitation from the bit-level rules.
  function automatic void model_excite(input logic [W-1:0] c, input logic [W-1:0] n,
                                       output logic [W-1:0] ej, output logic [W-1:0] ek);
    ej = '0;
    ek = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (c[i] != n[i]) begin
`ifdef JK_BANK_DRIVER_TOGGLE_EN
        ej[i] = 1'b1;
        ek[i] = 1'b1;
`else
        ej[i] = n[i];
        ek[i] = c[i];
`endif
      end
    end
  endfunction

  // Reference bank update: hold, set, reset or flip per bit.
  function automatic logic [W-1:0] model_apply(input logic [W-1:0] c, input logic [W-1:0] aj,
                                               input logic [W-1:0] ak);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      case ({aj[i], ak[i]})
        2'b00:   r[i] = c[i];
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = 1'b0;
        default: r[i] = ~c[i];
      endcase
    end
    return r;
  endfunction

  // One full transaction: preload bank, offer target, follow every cycle.
  task automatic run_word(input logic [W-1:0] q0, input logic [W-1:0] t,
                          input logic [W-1:0] m0, input logic [W-1:0] m1);
    logic [W-1:0] cur, ej, ek;
    int  rounds;
    int  w;
    bit  fin;
    w = 0;
    while (tgt_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (tgt_ready !== 1'b1) begin
      check_eq("ready_timeout", 32'(tgt_ready), 32'd1);
      return;
    end
    s0       = m0;
    s1       = m1;
    cur      = (q0 & ~m0) | m1;
    load_val = cur;
    load_en  = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
    tgt_valid = 1'b1;
    tgt_data  = t;
    rounds = 0;
    fin    = 1'b0;
    while (!fin) begin
      @(negedge clk);
      tgt_valid = 1'b0;
      tgt_data  = W'($urandom);
      model_excite(cur, t, ej, ek);
      check_eq("drive_j", 32'(j), 32'(ej));
      check_eq("drive_k", 32'(k), 32'(ek));
      check_eq("drive_busy_ready", 32'({busy, tgt_ready, done, err}), 32'b1000);
      cur = (model_apply(cur, ej, ek) & ~m0) | m1;
      @(negedge clk);
      check_eq("check_jk", 32'({j, k}), 32'd0);
      check_eq("check_busy_ready", 32'({busy, tgt_ready, done, err}), 32'b1000);
      if (cur == t) begin
        @(negedge clk);
        check_eq("done_cycle", 32'({busy, tgt_ready, done, err}), 32'b0110);
        fin = 1'b1;
      end else begin
        if (exp_mm < 16'hFFFF) exp_mm++;
        if (rounds < int'(MR)) begin
          rounds++;
        end else begin
          @(negedge clk);
          check_eq("err_cycle", 32'({busy, tgt_ready, done, err}), 32'b0101);
          fin = 1'b1;
        end
      end
    end
    check_eq("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mm));
    @(negedge clk);
    check_eq("pulse_end", 32'({done, err}), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rq, rt, rm0, rm1;
    int b;
    rst       = 1'b1;
    tgt_valid = 1'b1;
    tgt_data  = 8'hA5;
    load_en   = 1'b0;
    load_val  = '0;
    s0        = '0;
    s1        = '0;
    bank_q    = '0;

    // Reset held two cycles with valid offered.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("rst_jk", 32'({j, k}), 32'd0);
      check_eq("rst_flags", 32'({busy, tgt_ready, done, err}), 32'd0);
    end
    rst       = 1'b0;
    tgt_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(tgt_ready), 32'd1);
    check_eq("post_rst_cnt", 32'(mismatch_cnt), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Directed words.
    run_word(8'h00, 8'hA5, 8'h00, 8'h00);
    run_word(8'hF0, 8'h0F, 8'h00, 8'h00);
    run_word(8'h3C, 8'h3C, 8'h00, 8'h00);
    run_word(8'h00, 8'h01, 8'h01, 8'h00);
    check_eq("stuck_cnt_total", 32'(mismatch_cnt), 32'd3);

    // Reset during DRIVE aborts the word silently.
    s0       = '0;
    s1       = '0;
    load_val = 8'h00;
    load_en  = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
    tgt_valid = 1'b1;
    tgt_data  = 8'hFF;
    @(negedge clk);
    tgt_valid = 1'b0;
    check_eq("abort_drive_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_mm = 0;
    check_eq("abort_jk", 32'({j, k}), 32'd0);
    check_eq("abort_flags", 32'({busy, done, err}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("abort_no_pulse", 32'({busy, done, err}), 32'd0);
    end
    check_eq("abort_cnt", 32'(mismatch_cnt), 32'd0);
    run_word(8'h00, 8'h01, 8'h00, 8'h00);

    // Randomized words, some with one stuck bank bit.
    for (int n = 0; n < 40; n++) begin
      rq  = W'($urandom);
      rt  = W'($urandom);
      rm0 = '0;
      rm1 = '0;
      if ($urandom_range(0, 3) == 0) begin
        b = int'($urandom_range(0, W - 1));
        if ($urandom_range(0, 1) == 0) rm0[b] = 1'b1;
        else                           rm1[b] = 1'b1;
      end
      run_word(rq, rt, rm0, rm1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
